// File: rtl/closest_match_tracker_pkg.sv
// Shared types and constants for the closest-match tracker.
// Holds default bus width, FSM state type, all-ones distance.
package closest_pkg;

  localparam int ADDR_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [ADDR_W_DEF-1:0] DIST_MAX = '1;

endpackage

// File: rtl/closest_match_tracker_if.sv
// Result/summary bus between scan source and tracker.
// Optional thresh/hit_count exist under CLOSEST_THRESH_EN.
interface closest_match_tracker_if #(
  parameter int ADDR_W = 32
);

  logic              start;
  logic              result_en;
  logic [ADDR_W-1:0] result_addr;
  logic [ADDR_W-1:0] result;
  logic              busy;
  logic              best_valid;
  logic              best_ready;
  logic [ADDR_W-1:0] best_dist;
  logic [ADDR_W-1:0] best_addr;
  logic [ADDR_W-1:0] best_ties;
  logic              dropped;
`ifdef CLOSEST_THRESH_EN
  logic [ADDR_W-1:0] thresh;
  logic [ADDR_W-1:0] hit_count;
`endif

  modport master (
    output start,
    output result_en,
    output result_addr,
    output result,
    output best_ready,
`ifdef CLOSEST_THRESH_EN
    output thresh,
    input  hit_count,
`endif
    input  busy,
    input  best_valid,
    input  best_dist,
    input  best_addr,
    input  best_ties,
    input  dropped
  );

  modport slave (
    input  start,
    input  result_en,
    input  result_addr,
    input  result,
    input  best_ready,
`ifdef CLOSEST_THRESH_EN
    input  thresh,
    output hit_count,
`endif
    output busy,
    output best_valid,
    output best_dist,
    output best_addr,
    output best_ties,
    output dropped
  );

endinterface

// File: rtl/closest_match_tracker_min_cmp.sv
// Compares a new distance against the running best and
// produces less/equal flags plus a saturated tie increment.
module closest_min_cmp #(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] result,
  input  logic [ADDR_W-1:0] best_dist,
  input  logic [ADDR_W-1:0] best_ties,
  output logic              less,
  output logic              equal,
  output logic [ADDR_W-1:0] ties_inc
);

  // Flags and the tie counter that sticks at all-ones.
  always_comb begin
    less     = result < best_dist;
    equal    = result == best_dist;
    ties_inc = (&best_ties) ? best_ties
                            : best_ties + 1'b1;
  end

endmodule

// File: rtl/closest_match_tracker.sv
// Scans SKIP+SCAN_LEN results, reports min distance summary.
// Define CLOSEST_THRESH_EN to add thresh input and hit_count.
module closest_match_tracker
  import closest_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int SKIP     = 15,
  parameter int SCAN_LEN = 32'h659
) (
  input logic                    clk,
  input logic                    rst,
  closest_match_tracker_if.slave bus
);

  localparam logic [31:0] SKIP_L = 32'(SKIP);
  localparam logic [31:0] LAST_L = 32'(SKIP + SCAN_LEN - 1);

  state_t            state;
  logic [31:0]       seen;
  logic              busy_q;
  logic              valid_q;
  logic [ADDR_W-1:0] dist_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] ties_q;
  logic              drop_q;

  logic              less;
  logic              equal;
  logic [ADDR_W-1:0] ties_inc;

  logic restart;
  logic take;
  logic eval;
  logic last;
  logic drop_hit;
  logic accept;

  closest_min_cmp #(
    .ADDR_W(ADDR_W)
  ) u_cmp (
    .result    (bus.result),
    .best_dist (dist_q),
    .best_ties (ties_q),
    .less      (less),
    .equal     (equal),
    .ties_inc  (ties_inc)
  );

  // A start inside HOLD only counts when the summary is taken.
  always_comb begin
    accept   = (state == HOLD) && bus.best_ready;
    restart  = bus.start && ((state != HOLD) || accept);
    take     = (state == SCAN) && bus.result_en && !bus.start;
    eval     = take && (seen >= SKIP_L);
    last     = take && (seen == LAST_L);
    drop_hit = bus.result_en && (state != SCAN) && !restart;
  end

  // Scan FSM with all summary outputs held in registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      seen    <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      dist_q  <= '1;
      addr_q  <= '0;
      ties_q  <= '0;
      drop_q  <= 1'b0;
    end else if (restart) begin
      state   <= SCAN;
      seen    <= '0;
      busy_q  <= 1'b1;
      valid_q <= 1'b0;
      dist_q  <= '1;
      addr_q  <= '0;
      ties_q  <= '0;
      drop_q  <= 1'b0;
    end else begin
      if (drop_hit) drop_q <= 1'b1;
      if (take) seen <= seen + 32'd1;
      if (eval) begin
        unique case (1'b1)
          less: begin
            dist_q <= bus.result;
            addr_q <= bus.result_addr;
            ties_q <= {{(ADDR_W-1){1'b0}}, 1'b1};
          end
          equal: ties_q <= ties_inc;
          default: ;
        endcase
      end
      if (last) begin
        state   <= HOLD;
        busy_q  <= 1'b0;
        valid_q <= 1'b1;
      end
      if (accept) begin
        state   <= IDLE;
        valid_q <= 1'b0;
      end
    end
  end

`ifdef CLOSEST_THRESH_EN
  logic [ADDR_W-1:0] hits_q;

  // Counts evaluated results at or below thresh, saturating.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hits_q <= '0;
    end else if (restart) begin
      hits_q <= '0;
    end else if (eval && (bus.result <= bus.thresh)
                 && !(&hits_q)) begin
      hits_q <= hits_q + 1'b1;
    end
  end

  assign bus.hit_count = hits_q;
`endif

  assign bus.busy       = busy_q;
  assign bus.best_valid = valid_q;
  assign bus.best_dist  = dist_q;
  assign bus.best_addr  = addr_q;
  assign bus.best_ties  = ties_q;
  assign bus.dropped    = drop_q;

endmodule

// File: doc/closest_match_tracker.md
CLOSEST_MATCH_TRACKER -- requirements
Module: closest_match_tracker

Interface
REQ-001 Parameter ADDR_W, 32, width of address and result buses.
REQ-002 Parameter SKIP, 15, count of leading results discarded as pipeline warm-up (partial windows).
REQ-003 Parameter SCAN_LEN, 32'h659, count of results evaluated after SKIP; total results per scan = SKIP+SCAN_LEN.
REQ-004 clk  in  1  single clock, all logic on posedge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 start  in  1  one-cycle pulse; begins a new scan.
REQ-007 result_en  in  1  upstream edit-distance result valid.
REQ-008 result_addr  in  ADDR_W  window address of the result.
REQ-009 result  in  ADDR_W  edit distance of the window.
REQ-010 busy  out  1  high in SCAN.
REQ-011 best_valid  out  1  summary valid (valid/ready handshake).
REQ-012 best_ready  in  1  consumer accepts summary.
REQ-013 best_dist  out  ADDR_W  minimum distance of the scan.
REQ-014 best_addr  out  ADDR_W  first address achieving best_dist.
REQ-015 best_ties  out  ADDR_W  number of evaluated results equal to best_dist, saturating at all-ones.
REQ-016 dropped  out  1  sticky: result_en seen outside SCAN; cleared by start.

Function
REQ-017 FSM states IDLE, SCAN, HOLD; IDLE->SCAN on start; SCAN->HOLD on last counted result; HOLD->IDLE on best_valid&&best_ready.
REQ-018 On entering SCAN: seen counter=0, best_dist=all-ones, best_addr=0, best_ties=0, dropped=0.
REQ-019 In SCAN each result_en increments seen; results with seen<SKIP (pre-increment) are discarded.
REQ-020 Evaluated result<best_dist: best_dist=result, best_addr=result_addr, best_ties=1.
REQ-021 Evaluated result==best_dist: best_ties+1 (saturating), best_addr unchanged (first occurrence wins).
REQ-022 Evaluated result>best_dist: no change.
REQ-023 Result with seen==SKIP+SCAN_LEN-1 is evaluated, then FSM enters HOLD; best_valid high the next cycle (1-cycle latency).
REQ-024 In HOLD outputs best_* stable; best_valid stays high until best_ready sampled high; best_valid low the cycle after.
REQ-025 best_valid&&best_ready and a start in the same cycle: handshake completes, start honoured, FSM goes directly to SCAN.
REQ-026 start during SCAN: scan restarts (REQ-018); a result_en in the same cycle is discarded and not counted.
REQ-027 start during HOLD without best_ready: ignored.
REQ-028 result_en in IDLE or HOLD: ignored, dropped set.
REQ-029 SKIP=0 supported: first result is evaluated.

Reset
REQ-030 rst asserted: FSM=IDLE, busy=0, best_valid=0, best_dist=all-ones, best_addr=0, best_ties=0, dropped=0, seen=0, immediately and asynchronously.
REQ-031 rst mid-SCAN or mid-HOLD discards the scan; no summary is presented afterwards.

Configuration
REQ-032 Macro CLOSEST_THRESH_EN, when defined, adds input thresh (ADDR_W) and output hit_count (ADDR_W): count of evaluated results with result<=thresh, saturating, cleared with REQ-018 and reset, stable in HOLD.
REQ-033 CLOSEST_THRESH_EN undefined: thresh and hit_count ports and logic absent; all other behaviour identical.

Structure
REQ-034 Shared package closest_pkg holds ADDR_W default, the state enum typedef (IDLE/SCAN/HOLD), and the all-ones distance constant.
REQ-035 Sub-module closest_min_cmp: combinational compare producing less/equal flags and saturated tie increment; instantiated once.

Verification
REQ-036 SKIP=2,SCAN_LEN=4; results 0,0,7,3,3,9 at addrs 0..5 -> best_dist=3, best_addr=3, best_ties=2, best_valid 1 cycle after last result_en.
REQ-037 Hold best_ready low 10 cycles in HOLD -> best_valid and best_* stable; ready high -> valid low next cycle, busy=0.
REQ-038 result_en pulse in IDLE -> dropped=1; subsequent start -> dropped=0.
REQ-039 start pulse after 2 of 4 evaluated results -> trackers reset; next 6 results (SKIP=2) produce fresh summary unaffected by earlier values.
REQ-040 rst asserted mid-SCAN between clock edges -> best_valid=0, busy=0 before next edge; no summary follows.
REQ-041 CLOSEST_THRESH_EN defined, thresh=3, same stimulus as REQ-036 -> hit_count=2; macro undefined -> build succeeds with REQ-036 results unchanged.
